// File: rtl/rv32i_pkg.sv
// rv32i_pkg: RV32I opcodes, funct3 codes, ALU op encodings and NOP shared by decode.
package rv32i_pkg;
    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;
    localparam logic [2:0] F3_LB   = 3'b000;
    localparam logic [2:0] F3_LH   = 3'b001;
    localparam logic [2:0] F3_LW   = 3'b010;
    localparam logic [2:0] F3_LBU  = 3'b100;
    localparam logic [2:0] F3_LHU  = 3'b101;
    localparam logic [2:0] F3_SB   = 3'b000;
    localparam logic [2:0] F3_SH   = 3'b001;
    localparam logic [2:0] F3_SW   = 3'b010;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
    } alu_op_e;

    // alt selects SUB/SRA; callers only assert it where the encoding allows it
    function automatic alu_op_e alu_of(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction
endpackage

// File: rtl/id_regfile.sv
// id_regfile: 32x32 register file, one write port, two reads bypassed from the write port.
module id_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);
    logic [31:0] regs [32];

    always_ff @(posedge clk) begin
        if (rst)
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        else if (we && wa != '0)
            regs[wa] <= wd;
    end

    assign rd1 = ra1 == '0 ? '0 : (we && wa == ra1) ? wd : regs[ra1];
    assign rd2 = ra2 == '0 ? '0 : (we && wa == ra2) ? wd : regs[ra2];
endmodule

// File: rtl/id_stage.sv
// id_stage: RV32I decode stage with IF/ID latch, register file, and branch/jump
// resolution that redirects fetch and squashes the single wrong-path instruction.
module id_stage
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_NOP = NOP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc,
    input  logic [31:0] if_inst,
    input  logic        wb_we,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        brh,
    output logic [31:0] brh_addr,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_rs1_val,
    output logic [31:0] id_rs2_val,
    output logic [31:0] id_imm,
    output logic [4:0]  id_rd,
    output logic [2:0]  id_funct3,
    output logic [3:0]  id_alu_op,
    output logic        id_alu_src,
    output logic        id_mem_re,
    output logic        id_mem_we,
    output logic        id_reg_we,
    output logic        id_illegal
);
    logic [31:0] pc_q, inst_q, imm, target;
    logic        valid_q, ill, alu_src, mem_re, mem_we, writes, cond;
    alu_op_e     alu_op;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= '0;
            inst_q  <= RESET_NOP;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= if_pc;
            inst_q  <= brh ? RESET_NOP : if_inst;
            valid_q <= !brh;
        end
    end

    wire [6:0] opcode = inst_q[6:0];
    wire [2:0] funct3 = inst_q[14:12];
    wire [6:0] funct7 = inst_q[31:25];
    wire [4:0] rd     = inst_q[11:7];

    wire [31:0] imm_i = {{20{inst_q[31]}}, inst_q[31:20]};
    wire [31:0] imm_s = {{20{inst_q[31]}}, inst_q[31:25], inst_q[11:7]};
    wire [31:0] imm_b = {{19{inst_q[31]}}, inst_q[31], inst_q[7], inst_q[30:25], inst_q[11:8], 1'b0};
    wire [31:0] imm_u = {inst_q[31:12], 12'b0};
    wire [31:0] imm_j = {{11{inst_q[31]}}, inst_q[31], inst_q[19:12], inst_q[20], inst_q[30:21], 1'b0};

    id_regfile u_rf (
        .clk (clk),
        .rst (rst),
        .we  (wb_we),
        .wa  (wb_rd),
        .wd  (wb_data),
        .ra1 (inst_q[19:15]),
        .ra2 (inst_q[24:20]),
        .rd1 (id_rs1_val),
        .rd2 (id_rs2_val)
    );

    always_comb begin
        ill     = 1'b0;
        alu_op  = ALU_ADD;
        alu_src = 1'b0;
        mem_re  = 1'b0;
        mem_we  = 1'b0;
        writes  = 1'b0;
        imm     = '0;
        case (opcode)
            OPC_LUI:    begin imm = imm_u; alu_op = ALU_PASSB; alu_src = 1'b1; writes = 1'b1; end
            OPC_AUIPC:  begin imm = imm_u; alu_src = 1'b1; writes = 1'b1; end
            OPC_JAL:    begin imm = imm_j; writes = 1'b1; end
            OPC_JALR:   begin imm = imm_i; writes = 1'b1; ill = funct3 != 3'b000; end
            OPC_BRANCH: begin
                imm    = imm_b;
                alu_op = ALU_SUB;
                ill    = !(funct3 inside {F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU});
            end
            OPC_LOAD:   begin
                imm     = imm_i;
                alu_src = 1'b1;
                mem_re  = 1'b1;
                writes  = 1'b1;
                ill     = !(funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
            end
            OPC_STORE:  begin
                imm     = imm_s;
                alu_src = 1'b1;
                mem_we  = 1'b1;
                ill     = !(funct3 inside {F3_SB, F3_SH, F3_SW});
            end
            OPC_OP_IMM: begin
                imm     = imm_i;
                alu_src = 1'b1;
                writes  = 1'b1;
                alu_op  = alu_of(funct3, funct3 == 3'b101 && funct7[5]);
                ill     = (funct3 == 3'b001 && funct7 != '0) ||
                          (funct3 == 3'b101 && {funct7[6], funct7[4:0]} != '0);
            end
            OPC_OP:     begin
                writes = 1'b1;
                alu_op = alu_of(funct3, funct7[5]);
                ill    = {funct7[6], funct7[4:0]} != '0 ||
                         (funct7[5] && funct3 != 3'b000 && funct3 != 3'b101);
            end
            default:    ill = 1'b1;
        endcase
        if (ill) begin
            alu_op  = ALU_ADD;
            alu_src = 1'b0;
            mem_re  = 1'b0;
            mem_we  = 1'b0;
            writes  = 1'b0;
        end
    end

    // funct3[2:1] picks eq/signed/unsigned compare, funct3[0] inverts it
    always_comb begin
        cond   = (funct3[2:1] == 2'b00 ? id_rs1_val == id_rs2_val :
                  funct3[2:1] == 2'b10 ? $signed(id_rs1_val) < $signed(id_rs2_val) :
                                         id_rs1_val < id_rs2_val) ^ funct3[0];
        target = opcode == OPC_JALR ? (id_rs1_val + imm_i) & ~32'd1 : pc_q + imm;
    end

    assign brh = valid_q && !ill && !rst &&
                 (opcode == OPC_JAL || opcode == OPC_JALR || (opcode == OPC_BRANCH && cond));
    assign brh_addr   = brh ? target : '0;
    assign id_valid   = valid_q;
    assign id_pc      = pc_q;
    assign id_imm     = imm;
    assign id_rd      = writes ? rd : '0;
    assign id_funct3  = funct3;
    assign id_alu_op  = alu_op;
    assign id_alu_src = alu_src;
    assign id_mem_re  = valid_q && mem_re;
    assign id_mem_we  = valid_q && mem_we;
    assign id_reg_we  = valid_q && writes && rd != '0;
    assign id_illegal = valid_q && ill;
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed vectors for id_stage; expectations queue per cycle, a monitor checks them.
module tb_id_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0, rst = 1'b1;
    logic [31:0] if_pc = '0, if_inst = 32'h0050_0093;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;
    logic        brh, id_valid, id_alu_src, id_mem_re, id_mem_we, id_reg_we, id_illegal;
    logic [31:0] brh_addr, id_pc, id_rs1_val, id_rs2_val, id_imm;
    logic [4:0]  id_rd;
    logic [2:0]  id_funct3;
    logic [3:0]  id_alu_op;

    id_stage dut (
        .clk        (clk),
        .rst        (rst),
        .if_pc      (if_pc),
        .if_inst    (if_inst),
        .wb_we      (wb_we),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .brh        (brh),
        .brh_addr   (brh_addr),
        .id_valid   (id_valid),
        .id_pc      (id_pc),
        .id_rs1_val (id_rs1_val),
        .id_rs2_val (id_rs2_val),
        .id_imm     (id_imm),
        .id_rd      (id_rd),
        .id_funct3  (id_funct3),
        .id_alu_op  (id_alu_op),
        .id_alu_src (id_alu_src),
        .id_mem_re  (id_mem_re),
        .id_mem_we  (id_mem_we),
        .id_reg_we  (id_reg_we),
        .id_illegal (id_illegal)
    );

    always #5 clk = ~clk;

    typedef enum {F_VALID, F_BRH, F_ADDR, F_PC, F_RS1, F_RS2, F_IMM, F_RD,
                  F_REGWE, F_MEMRE, F_MEMWE, F_ILL} fld_e;
    typedef struct {
        int          cyc;
        fld_e        f;
        logic [31:0] v;
        string       n;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0, tests = 0, fails = 0;
    logic done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] act(input fld_e f);
        case (f)
            F_VALID: return {31'b0, id_valid};
            F_BRH:   return {31'b0, brh};
            F_ADDR:  return brh_addr;
            F_PC:    return id_pc;
            F_RS1:   return id_rs1_val;
            F_RS2:   return id_rs2_val;
            F_IMM:   return id_imm;
            F_RD:    return {27'b0, id_rd};
            F_REGWE: return {31'b0, id_reg_we};
            F_MEMRE: return {31'b0, id_mem_re};
            F_MEMWE: return {31'b0, id_mem_we};
            default: return {31'b0, id_illegal};
        endcase
    endfunction

    // monitor: compares every expectation due in the current cycle; leftovers fail at the end
    always @(negedge clk) begin
        int i;
        logic [31:0] a;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].cyc == cyc) begin
                a = act(sb[i].f);
                tests++;
                if (a !== sb[i].v) begin
                    fails++;
                    $display("FAIL %s: got %h want %h (cycle %0d)", sb[i].n, a, sb[i].v, cyc);
                end
                sb.delete(i);
            end else if (done) begin
                tests++;
                fails++;
                $display("FAIL %s: never sampled, want %h at cycle %0d", sb[i].n, sb[i].v, sb[i].cyc);
                sb.delete(i);
            end else begin
                i++;
            end
        end
    end

    task automatic chk(input int d, input fld_e f, input logic [31:0] v, input string n);
        sb.push_back('{cyc + d, f, v, n});
    endtask

    task automatic step(input logic r, input logic [31:0] pc, input logic [31:0] inst,
                        input logic we, input logic [4:0] rd, input logic [31:0] d);
        rst = r; if_pc = pc; if_inst = inst; wb_we = we; wb_rd = rd; wb_data = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        @(posedge clk);
        #1;
        chk(0, F_VALID, 0, "rst_valid");
        chk(0, F_BRH, 0, "rst_brh");
        step(1, 0, 32'h0050_0093, 0, 0, 0);
        chk(0, F_VALID, 0, "post_rst_valid");
        for (int i = 0; i < 16; i++) begin
            chk(1, F_RS1, 0, $sformatf("rst_reg_x%0d", 2 * i));
            chk(1, F_RS2, 0, $sformatf("rst_reg_x%0d", 2 * i + 1));
            step(0, 32'(4 * i), {7'b0, 5'(2 * i + 1), 5'(2 * i), 3'b0, 5'b0, 7'b0110011}, 0, 0, 0);
        end
        // addi x6,x5,1 with x5 written by WB in the same cycle
        chk(1, F_RS1, 32'h1234, "wb_bypass");
        chk(1, F_IMM, 1, "addi_imm");
        chk(1, F_REGWE, 1, "addi_regwe");
        chk(1, F_RD, 6, "addi_rd");
        step(0, 32'h40, 32'h0012_8313, 0, 0, 0);
        step(0, 32'h44, NOP, 1, 5, 32'h1234);
        chk(1, F_RS1, 32'h1234, "wb_stored");
        chk(1, F_REGWE, 0, "rd0_no_we");
        step(0, 32'h48, 32'h0002_8033, 0, 0, 0);
        chk(1, F_RS1, 0, "x0_bypass");
        step(0, 32'h4c, 32'h0000_0033, 0, 0, 0);
        step(0, 32'h50, NOP, 1, 0, 32'hFFFF);
        chk(1, F_RS1, 0, "x0_read");
        step(0, 32'h54, 32'h0000_0033, 0, 0, 0);
        // beq x1,x2,+16 taken; the copy fetched at 0x104 must be squashed
        step(0, 0, NOP, 1, 1, 7);
        step(0, 0, NOP, 1, 2, 7);
        chk(1, F_BRH, 1, "beq_brh");
        chk(1, F_ADDR, 32'h110, "beq_addr");
        chk(2, F_VALID, 0, "beq_squash");
        chk(2, F_BRH, 0, "beq_no_rebrh");
        chk(2, F_PC, 32'h104, "squash_pc");
        step(0, 32'h100, 32'h0020_8863, 0, 0, 0);
        step(0, 32'h104, 32'h0020_8863, 0, 0, 0);
        step(0, 32'h108, NOP, 0, 0, 0);
        // signed vs unsigned compare
        step(0, 0, NOP, 1, 1, 32'hFFFF_FFFF);
        step(0, 0, NOP, 1, 2, 1);
        chk(1, F_BRH, 1, "blt_brh");
        chk(1, F_ADDR, 32'h208, "blt_addr");
        chk(2, F_VALID, 0, "blt_squash");
        step(0, 32'h200, 32'h0020_C463, 0, 0, 0);
        step(0, 32'h204, NOP, 0, 0, 0);
        chk(1, F_BRH, 0, "bltu_brh");
        chk(1, F_VALID, 1, "bltu_valid");
        chk(1, F_ADDR, 0, "bltu_addr");
        step(0, 32'h300, 32'h0020_E463, 0, 0, 0);
        // jumps
        step(0, 0, NOP, 1, 1, 32'h203);
        chk(1, F_BRH, 1, "jalr_brh");
        chk(1, F_ADDR, 32'h206, "jalr_addr");
        chk(1, F_RD, 0, "jalr_rd");
        chk(1, F_REGWE, 0, "jalr_regwe");
        step(0, 32'h400, 32'h0040_8067, 0, 0, 0);
        step(0, 32'h404, NOP, 0, 0, 0);
        chk(1, F_BRH, 1, "jal_brh");
        chk(1, F_ADDR, 32'h78, "jal_addr");
        chk(1, F_RD, 1, "jal_rd");
        chk(1, F_IMM, 32'hFFFF_FFF8, "jal_imm");
        chk(1, F_PC, 32'h80, "jal_pc");
        step(0, 32'h80, 32'hFF9F_F0EF, 0, 0, 0);
        step(0, 32'h84, NOP, 0, 0, 0);
        // store / load
        chk(1, F_MEMWE, 1, "sw_memwe");
        chk(1, F_IMM, 8, "sw_imm");
        chk(1, F_REGWE, 0, "sw_regwe");
        chk(1, F_RS2, 1, "sw_rs2");
        step(0, 32'h500, 32'h0020_A423, 0, 0, 0);
        chk(1, F_MEMRE, 1, "lw_memre");
        chk(1, F_RD, 3, "lw_rd");
        chk(1, F_REGWE, 1, "lw_regwe");
        chk(1, F_MEMWE, 0, "lw_memwe");
        step(0, 32'h504, 32'h0040_A183, 0, 0, 0);
        // reset while a taken beq sits in ID
        step(0, 0, NOP, 1, 1, 9);
        step(0, 0, NOP, 1, 2, 9);
        chk(1, F_VALID, 1, "rst_beq_valid");
        chk(1, F_BRH, 0, "rst_beq_brh");
        chk(1, F_ADDR, 0, "rst_beq_addr");
        chk(2, F_VALID, 0, "rst_next_valid");
        step(0, 32'h600, 32'h0020_8863, 0, 0, 0);
        step(1, 32'h604, NOP, 0, 0, 0);
        chk(1, F_RS1, 0, "rst_clear_x1");
        chk(1, F_RS2, 0, "rst_clear_x2");
        step(0, 32'h700, 32'h0020_8033, 0, 0, 0);
        // illegal instruction
        chk(1, F_ILL, 1, "ill_flag");
        chk(1, F_MEMRE, 0, "ill_memre");
        chk(1, F_MEMWE, 0, "ill_memwe");
        chk(1, F_REGWE, 0, "ill_regwe");
        chk(1, F_BRH, 0, "ill_brh");
        step(0, 32'h704, 32'hFFFF_FFFF, 0, 0, 0);
        step(0, 32'h708, NOP, 0, 0, 0);
        step(0, 32'h70c, NOP, 0, 0, 0);
        done = 1'b1;
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
